// File: rtl/tia_hcount_pkg.sv
// Shared constants for the TIA horizontal counter: LFSR step function, line indices,
// the LFSR states those indices map to, and the phase-tracker state type.
package tia_hcount_pkg;

  localparam int unsigned LFSR_W = 6;

  localparam int unsigned HSYNC_SET_IDX       = 4;
  localparam int unsigned HSYNC_CLR_IDX       = 8;
  localparam int unsigned HBLANK_CLR_IDX      = 16;
  localparam int unsigned HBLANK_CLR_LATE_IDX = 18;
  localparam int unsigned WRAP_IDX            = 56;

  typedef enum logic {
    WAIT_PHI1 = 1'b0,
    WAIT_PHI2 = 1'b1
  } phase_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[LFSR_W-1] ^ s[LFSR_W-2])};
  endfunction

  // LFSR state reached after idx steps from 0; fixed trip count keeps it synthesizable
  function automatic logic [LFSR_W-1:0] state_at(input logic [LFSR_W-1:0] idx);
    logic [LFSR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < WRAP_IDX; i++) begin
      if (LFSR_W'(i) < idx) s = lfsr_next(s);
    end
    return s;
  endfunction

  localparam logic [LFSR_W-1:0] STATE_HSYNC_SET       = state_at(LFSR_W'(HSYNC_SET_IDX));
  localparam logic [LFSR_W-1:0] STATE_HSYNC_CLR       = state_at(LFSR_W'(HSYNC_CLR_IDX));
  localparam logic [LFSR_W-1:0] STATE_HBLANK_CLR      = state_at(LFSR_W'(HBLANK_CLR_IDX));
  localparam logic [LFSR_W-1:0] STATE_HBLANK_CLR_LATE = state_at(LFSR_W'(HBLANK_CLR_LATE_IDX));
  localparam logic [LFSR_W-1:0] STATE_WRAP            = state_at(LFSR_W'(WRAP_IDX));

endpackage

// File: rtl/tia_hsync_counter_if.sv
// Strobe inputs and timing-decode outputs of the horizontal sync counter.
// TIA_HCOUNT_INDEX_EN adds the binary hindex shadow output.
interface tia_hsync_counter_if;
  import tia_hcount_pkg::*;

  logic              hphi1_en;
  logic              hphi2_en;
  logic              rsyn;
  logic              hmove;
  logic [LFSR_W-1:0] hcount;
  logic              hsync;
  logic              hblank;
  logic              line_end;
  logic              phase_err;
`ifdef TIA_HCOUNT_INDEX_EN
  logic [LFSR_W-1:0] hindex;

  modport master (output hphi1_en, hphi2_en, rsyn, hmove,
                  input  hcount, hsync, hblank, line_end, phase_err, hindex);
  modport slave  (input  hphi1_en, hphi2_en, rsyn, hmove,
                  output hcount, hsync, hblank, line_end, phase_err, hindex);
`else
  modport master (output hphi1_en, hphi2_en, rsyn, hmove,
                  input  hcount, hsync, hblank, line_end, phase_err);
  modport slave  (input  hphi1_en, hphi2_en, rsyn, hmove,
                  output hcount, hsync, hblank, line_end, phase_err);
`endif

endinterface

// File: rtl/tia_hcount_phase_tracker.sv
// Checks phi1/phi2 alternation, qualifies the master/slave load strobes and holds
// the sticky phase_err flag.
module tia_hcount_phase_tracker
  import tia_hcount_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hphi1_en,
  input  logic hphi2_en,
  input  logic fault_c,
  output logic load_master_c,
  output logic load_slave_c,
  output logic phase_err
);

  phase_state_e state_q, state_d;
  logic         phase_err_q, phase_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_PHI1;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_err_q <= phase_err_d;
    end
  end

  // Out-of-order or simultaneous strobes are flagged and otherwise ignored
  always_comb begin
    state_d       = state_q;
    phase_err_d   = phase_err_q | fault_c;
    load_master_c = 1'b0;
    load_slave_c  = 1'b0;
    if (hphi1_en && hphi2_en) begin
      phase_err_d = 1'b1;
    end else begin
      case (state_q)
        WAIT_PHI1: begin
          if (hphi1_en) begin
            load_master_c = 1'b1;
            state_d       = WAIT_PHI2;
          end else if (hphi2_en) begin
            phase_err_d = 1'b1;
          end
        end
        WAIT_PHI2: begin
          if (hphi2_en) begin
            load_slave_c = 1'b1;
            state_d      = WAIT_PHI1;
          end else if (hphi1_en) begin
            phase_err_d = 1'b1;
          end
        end
        default: state_d = WAIT_PHI1;
      endcase
    end
  end

  assign phase_err = phase_err_q;

endmodule

// File: rtl/tia_hsync_counter.sv
// TIA horizontal sync counter: 6-bit master/slave LFSR with hsync/hblank/line_end decodes.
// Optional build macro TIA_HCOUNT_INDEX_EN adds the hindex shadow counter and its self-check.
module tia_hsync_counter
  import tia_hcount_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  tia_hsync_counter_if.slave  bus
);

  logic              load_master_c, load_slave_c, index_err_c, wrap_c, late_eff_c;
  logic              phase_err;
  logic [LFSR_W-1:0] master_q, master_d, hcount_q, hcount_d;
  logic              wrap_pend_q, wrap_pend_d;
  logic              line_end_q, line_end_d;
  logic              hsync_q, hsync_d, hblank_q, hblank_d;
  logic              late_q, late_d, late_next_q, late_next_d, passed_q, passed_d;

  tia_hcount_phase_tracker u_tracker (
    .clk           (clk),
    .reset         (reset),
    .hphi1_en      (bus.hphi1_en),
    .hphi2_en      (bus.hphi2_en),
    .fault_c       (index_err_c),
    .load_master_c (load_master_c),
    .load_slave_c  (load_slave_c),
    .phase_err     (phase_err)
  );

  assign wrap_c     = (hcount_q == STATE_WRAP);
  assign late_eff_c = late_q | (bus.hmove & ~passed_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      master_q    <= '0;
      hcount_q    <= '0;
      wrap_pend_q <= 1'b0;
      line_end_q  <= 1'b0;
      hsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      late_q      <= 1'b0;
      late_next_q <= 1'b0;
      passed_q    <= 1'b0;
    end else begin
      master_q    <= master_d;
      hcount_q    <= hcount_d;
      wrap_pend_q <= wrap_pend_d;
      line_end_q  <= line_end_d;
      hsync_q     <= hsync_d;
      hblank_q    <= hblank_d;
      late_q      <= late_d;
      late_next_q <= late_next_d;
      passed_q    <= passed_d;
    end
  end

  always_comb begin
    master_d    = master_q;
    hcount_d    = hcount_q;
    wrap_pend_d = wrap_pend_q;
    line_end_d  = 1'b0;
    hsync_d     = hsync_q;
    hblank_d    = hblank_q;
    late_d      = late_q;
    late_next_d = late_next_q;
    passed_d    = passed_q;

    // hmove after the HBLANK_CLR decision is deferred to the following line
    if (bus.hmove) begin
      if (passed_q) late_next_d = 1'b1;
      else          late_d      = 1'b1;
    end

    if (load_master_c) begin
      master_d    = (bus.rsyn || wrap_c) ? '0 : lfsr_next(hcount_q);
      wrap_pend_d = wrap_c && !bus.rsyn;
    end

    // Decodes track the value entering hcount so they change on the same edge
    if (load_slave_c) begin
      hcount_d    = master_q;
      line_end_d  = wrap_pend_q;
      wrap_pend_d = 1'b0;
      if (master_q == '0) begin
        hblank_d    = 1'b1;
        hsync_d     = 1'b0;
        passed_d    = 1'b0;
        late_d      = late_next_q | bus.hmove;
        late_next_d = 1'b0;
      end else if (master_q == STATE_HSYNC_SET) begin
        hsync_d = 1'b1;
      end else if (master_q == STATE_HSYNC_CLR) begin
        hsync_d = 1'b0;
      end else if (master_q == STATE_HBLANK_CLR) begin
        passed_d = 1'b1;
        if (!late_eff_c) hblank_d = 1'b0;
      end else if (master_q == STATE_HBLANK_CLR_LATE) begin
        if (late_q) hblank_d = 1'b0;
      end
    end
  end

`ifdef TIA_HCOUNT_INDEX_EN
  logic [LFSR_W-1:0] hindex_master_q, hindex_master_d, hindex_q, hindex_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hindex_master_q <= '0;
      hindex_q        <= '0;
    end else begin
      hindex_master_q <= hindex_master_d;
      hindex_q        <= hindex_d;
    end
  end

  // Binary shadow follows the same master/slave load sequence as the LFSR
  always_comb begin
    hindex_master_d = hindex_master_q;
    hindex_d        = hindex_q;
    if (load_master_c) hindex_master_d = (bus.rsyn || wrap_c) ? '0 : LFSR_W'(hindex_q + 1'b1);
    if (load_slave_c)  hindex_d = hindex_master_q;
  end

  assign index_err_c = (hcount_q != state_at(hindex_q));
  assign bus.hindex  = hindex_q;
`else
  assign index_err_c = 1'b0;
`endif

  assign bus.hcount    = hcount_q;
  assign bus.hsync     = hsync_q;
  assign bus.hblank    = hblank_q;
  assign bus.line_end  = line_end_q;
  assign bus.phase_err = phase_err;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Self-checking bench for tia_hsync_counter against a line-index reference model.
module tb_tia_hsync_counter;

  logic clk = 1'b0;
  logic reset;

  tia_hsync_counter_if bus();

  tia_hsync_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] tbl [0:56];
  int         m_idx;
  bit         m_late;
  bit         m_le;

  function automatic bit exp_hsync();
    return (m_idx >= 4) && (m_idx < 8);
  endfunction

  function automatic bit exp_hblank();
    return (m_idx < 16) || (m_late && (m_idx < 18));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.hphi1_en = 1'b0; bus.hphi2_en = 1'b0; bus.rsyn = 1'b0; bus.hmove = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_idx = 0; m_late = 1'b0; m_le = 1'b0;
  endtask

  // One phi1/phi2 pair with gap idle clocks between; model advances by line rules
  task automatic run_pair(input bit rs, input int gap);
    bit wrap;
    bus.rsyn = rs; bus.hphi1_en = 1'b1;
    tick();
    bus.rsyn = 1'b0; bus.hphi1_en = 1'b0;
    repeat (gap) tick();
    bus.hphi2_en = 1'b1;
    tick();
    bus.hphi2_en = 1'b0;
    wrap = (m_idx == 56);
    m_le = wrap && !rs;
    if (rs || wrap) begin
      m_idx = 0;
      m_late = 1'b0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.hcount !== 6'd0) begin errors++; $display("FAIL reset_hcount got %0h exp 0", bus.hcount); end
    if (bus.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b exp 0", bus.hsync); end
    if (bus.hblank !== 1'b1) begin errors++; $display("FAIL reset_hblank got %b exp 1", bus.hblank); end
    if (bus.line_end !== 1'b0) begin errors++; $display("FAIL reset_line_end got %b exp 0", bus.line_end); end
    if (bus.phase_err !== 1'b0) begin errors++; $display("FAIL reset_phase_err got %b exp 0", bus.phase_err); end
  endtask

  task automatic test_line_walk();
    int pulses = 0;
    for (int p = 1; p <= 57; p++) begin
      run_pair(1'b0, int'($urandom_range(0, 3)));
      if (bus.line_end === 1'b1) pulses++;
      checks += 2;
      if (bus.hcount !== tbl[m_idx]) begin
        errors++; $display("FAIL walk_hcount pair %0d got %0h exp %0h", p, bus.hcount, tbl[m_idx]);
      end
      if (bus.line_end !== m_le) begin
        errors++; $display("FAIL walk_line_end pair %0d got %b exp %b", p, bus.line_end, m_le);
      end
    end
    checks += 3;
    if (m_idx != 0 || bus.hcount !== 6'd0) begin
      errors++; $display("FAIL walk_wrap got %0h exp 0", bus.hcount);
    end
    if (pulses != 1) begin errors++; $display("FAIL walk_pulses got %0d exp 1", pulses); end
    tick();
    if (bus.line_end !== 1'b0) begin errors++; $display("FAIL walk_line_end_width got %b exp 0", bus.line_end); end
  endtask

  task automatic test_free_run();
    int hs_cnt = 0;
    for (int p = 0; p < 3 * 57; p++) begin
      run_pair(1'b0, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) tick();
      if (bus.hsync === 1'b1) hs_cnt++;
      checks += 3;
      if (bus.hcount !== tbl[m_idx]) begin
        errors++; $display("FAIL run_hcount idx %0d got %0h exp %0h", m_idx, bus.hcount, tbl[m_idx]);
      end
      if (bus.hsync !== exp_hsync()) begin
        errors++; $display("FAIL run_hsync idx %0d got %b exp %b", m_idx, bus.hsync, exp_hsync());
      end
      if (bus.hblank !== exp_hblank()) begin
        errors++; $display("FAIL run_hblank idx %0d got %b exp %b", m_idx, bus.hblank, exp_hblank());
      end
      if (m_idx == 0) begin
        checks++;
        if (hs_cnt != 4) begin errors++; $display("FAIL run_hsync_len got %0d exp 4", hs_cnt); end
        hs_cnt = 0;
      end
    end
  endtask

  task automatic test_hmove();
    while (m_idx != 10) run_pair(1'b0, 0);
    bus.hmove = 1'b1;
    tick();
    bus.hmove = 1'b0;
    m_late = 1'b1;
    for (int p = 0; p < 47 + 57; p++) begin
      run_pair(1'b0, int'($urandom_range(0, 1)));
      checks++;
      if (bus.hblank !== exp_hblank()) begin
        errors++; $display("FAIL hmove_hblank idx %0d late %b got %b exp %b", m_idx, m_late, bus.hblank, exp_hblank());
      end
    end
  endtask

  task automatic test_rsyn();
    int len = 0;
    while (m_idx != 30) run_pair(1'b0, 0);
    run_pair(1'b1, 1);
    checks += 2;
    if (bus.hcount !== 6'd0) begin errors++; $display("FAIL rsyn_hcount got %0h exp 0", bus.hcount); end
    if (bus.line_end !== 1'b0) begin errors++; $display("FAIL rsyn_line_end got %b exp 0", bus.line_end); end
    for (int p = 0; p < 60 && bus.line_end !== 1'b1; p++) begin
      run_pair(1'b0, 0);
      len++;
    end
    checks++;
    if (len != 57) begin errors++; $display("FAIL rsyn_line_len got %0d exp 57", len); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 300; p++) begin
      if (m_idx < 16 && $urandom_range(0, 7) == 0) begin
        bus.hmove = 1'b1;
        tick();
        bus.hmove = 1'b0;
        m_late = 1'b1;
      end
      run_pair(($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
      checks += 4;
      if (bus.hcount !== tbl[m_idx]) begin
        errors++; $display("FAIL rand_hcount idx %0d got %0h exp %0h", m_idx, bus.hcount, tbl[m_idx]);
      end
      if (bus.hsync !== exp_hsync()) begin
        errors++; $display("FAIL rand_hsync idx %0d got %b exp %b", m_idx, bus.hsync, exp_hsync());
      end
      if (bus.hblank !== exp_hblank()) begin
        errors++; $display("FAIL rand_hblank idx %0d got %b exp %b", m_idx, bus.hblank, exp_hblank());
      end
      if (bus.line_end !== m_le) begin
        errors++; $display("FAIL rand_line_end idx %0d got %b exp %b", m_idx, bus.line_end, m_le);
      end
    end
    checks++;
    if (bus.phase_err !== 1'b0) begin errors++; $display("FAIL rand_phase_err got %b exp 0", bus.phase_err); end
  endtask

  task automatic test_phase_err();
    do_reset();
    repeat (3) run_pair(1'b0, 0);
    bus.hphi2_en = 1'b1;
    tick();
    bus.hphi2_en = 1'b0;
    checks += 2;
    if (bus.phase_err !== 1'b1) begin errors++; $display("FAIL lone_phi2_err got %b exp 1", bus.phase_err); end
    if (bus.hcount !== tbl[3]) begin errors++; $display("FAIL lone_phi2_hcount got %0h exp %0h", bus.hcount, tbl[3]); end

    do_reset();
    repeat (3) run_pair(1'b0, 0);
    bus.hphi1_en = 1'b1; bus.hphi2_en = 1'b1;
    tick();
    bus.hphi1_en = 1'b0; bus.hphi2_en = 1'b0;
    tick();
    checks += 2;
    if (bus.phase_err !== 1'b1) begin errors++; $display("FAIL both_err got %b exp 1", bus.phase_err); end
    if (bus.hcount !== tbl[3]) begin errors++; $display("FAIL both_hcount got %0h exp %0h", bus.hcount, tbl[3]); end
    run_pair(1'b0, 0);
    checks++;
    if (bus.hcount !== tbl[4]) begin errors++; $display("FAIL both_recover got %0h exp %0h", bus.hcount, tbl[4]); end
  endtask

  task automatic test_reset_midpair();
    do_reset();
    repeat (20) run_pair(1'b0, 0);
    bus.hphi1_en = 1'b1;
    tick();
    bus.hphi1_en = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    checks += 5;
    if (bus.hcount !== 6'd0) begin errors++; $display("FAIL mid_hcount got %0h exp 0", bus.hcount); end
    if (bus.hblank !== 1'b1) begin errors++; $display("FAIL mid_hblank got %b exp 1", bus.hblank); end
    if (bus.hsync !== 1'b0) begin errors++; $display("FAIL mid_hsync got %b exp 0", bus.hsync); end
    if (bus.line_end !== 1'b0) begin errors++; $display("FAIL mid_line_end got %b exp 0", bus.line_end); end
    if (bus.phase_err !== 1'b0) begin errors++; $display("FAIL mid_phase_err got %b exp 0", bus.phase_err); end
    tick();
    reset = 1'b1;
    m_idx = 0; m_late = 1'b0;
    run_pair(1'b0, 0);
    checks += 2;
    if (bus.hcount !== tbl[1]) begin errors++; $display("FAIL mid_after_hcount got %0h exp %0h", bus.hcount, tbl[1]); end
    if (bus.phase_err !== 1'b0) begin errors++; $display("FAIL mid_after_err got %b exp 0", bus.phase_err); end

    repeat (5) run_pair(1'b0, 0);
    bus.hphi1_en = 1'b1;
    tick();
    bus.hphi1_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.hphi2_en = 1'b1;
    tick();
    bus.hphi2_en = 1'b0;
    checks += 2;
    if (bus.phase_err !== 1'b1) begin errors++; $display("FAIL mid_orphan_phi2 got %b exp 1", bus.phase_err); end
    if (bus.hcount !== 6'd0) begin errors++; $display("FAIL mid_orphan_hcount got %0h exp 0", bus.hcount); end
  endtask

  initial begin
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i <= 56; i++) begin
      tbl[i] = s;
      s = {s[4:0], ~(s[5] ^ s[4])};
    end
    reset = 1'b0;
    bus.hphi1_en = 1'b0; bus.hphi2_en = 1'b0; bus.rsyn = 1'b0; bus.hmove = 1'b0;
    test_reset();
    test_line_walk();
    test_free_run();
    test_hmove();
    test_rsyn();
    test_random();
    test_phase_err();
    test_reset_midpair();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
